// File: rtl/seven_seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer: per-slot blank/show phases, leading-zero
// suppression, and a shadowed display value that only swaps at frame boundaries.

module seven_seg_scan_lane #(
    parameter int LANE = 0
) (
    input  logic [15:0] display,
    input  logic        en,
    input  logic        lz_blank,
    output logic        lit
);
    localparam bit CAN_BLANK = (LANE != 0);

    logic [15:0] upper;

    assign upper = display >> (4 * LANE);
    assign lit   = en & ~(lz_blank & CAN_BLANK & (upper == 16'd0));
endmodule

module seven_seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        value_load,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);
    localparam int NUM_DIGITS = 4;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              idx;
    logic [15:0]             shadow;
    logic [15:0]             display;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   lit;

    logic        slot_end;
    logic        frame_end;
    logic [1:0]  idx_nxt;
    logic [15:0] next_display;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        seven_seg_scan_lane #(.LANE(g)) u_lane (
            .display  (display),
            .en       (digit_en[g]),
            .lz_blank (lz_blank),
            .lit      (lit[g])
        );
    end

    assign slot_end  = (cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign idx_nxt   = idx + 2'd1;
    assign dp        = 1'b1;

    // A load coinciding with the boundary bypasses the shadow so it is not lost for a frame.
    always_comb begin
        next_display = display;
        if (frame_end) begin
            if (value_load)
                next_display = value_in;
            else if (pending)
                next_display = shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 16'd0;
            display    <= 16'd0;
            pending    <= 1'b0;
            an         <= 4'b1111;
            nibble     <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lands on the boundary cycle itself.
            frame_done <= (idx == 2'd3) && (cnt == PRE_LAST);

            if (value_load)
                shadow <= value_in;
            if (frame_end) begin
                display <= next_display;
                pending <= 1'b0;
            end else if (value_load) begin
                pending <= 1'b1;
            end

            case (state)
                BLANK: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        an    <= lit[idx] ? ~(4'b0001 << idx) : 4'b1111;
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        cnt    <= '0;
                        idx    <= idx_nxt;
                        state  <= BLANK;
                        an     <= 4'b1111;
                        nibble <= next_display[{idx_nxt, 2'b00} +: 4];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux: cycle-count reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized stretch.

module tb_seven_seg_scan_mux;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = 16'd0;
    logic        value_load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    seven_seg_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .value_load (value_load),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .nibble     (nibble),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: t counts cycles since the last reset edge; the frame value and the
    // newest load are tracked as plain values.
    int          t = 0;
    logic [15:0] disp = 16'd0;
    logic [15:0] latest = 16'd0;
    bit          have_new = 1'b0;
    bit          shown = 1'b0;
    bit          started = 1'b0;

    function automatic int cur_ph();
        return t % RD;
    endfunction

    function automatic int cur_sl();
        return (t / RD) % 4;
    endfunction

    function automatic logic [3:0] m_an();
        if (cur_ph() >= BC && shown)
            return ~(4'b0001 << cur_sl());
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_nib();
        logic [15:0] s;
        s = disp >> (4 * cur_sl());
        return s[3:0];
    endfunction

    function automatic logic m_fd();
        return (cur_sl() == 3) && (cur_ph() == RD - 1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            t        = 0;
            disp     = 16'd0;
            have_new = 1'b0;
            shown    = 1'b0;
            started  = 1'b1;
        end else begin
            if (value_load) begin
                latest   = value_in;
                have_new = 1'b1;
            end
            if (cur_ph() == BC - 1)
                shown = digit_en[cur_sl()] &&
                        !(lz_blank && cur_sl() != 0 && (disp >> (4 * cur_sl())) == 16'd0);
            if (cur_sl() == 3 && cur_ph() == RD - 1 && have_new) begin
                disp     = latest;
                have_new = 1'b0;
            end
            t = t + 1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", nm, act, exp, t, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("an", 16'(an), 16'(m_an()));
            chk("nibble", 16'(nibble), 16'(m_nib()));
            chk("dp", 16'(dp), 16'd1);
            chk("frame_done", 16'(frame_done), 16'(m_fd()));
            chk("an_onehot", 16'($countones(~an) <= 1), 16'd1);
            chk("an_in_blank", 16'(cur_ph() < BC && an != 4'hF), 16'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int sl, input int ph);
        int k;
        k = 0;
        while (!(cur_sl() == sl && cur_ph() == ph) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL timeout: slot %0d phase %0d not reached", sl, ph);
        end
    endtask

    task automatic next_frame();
        wait_until(3, RD - 1);
        cyc(1);
    endtask

    task automatic load(input logic [15:0] v);
        value_in   = v;
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
        value_in   = 16'($urandom);
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit_chk(input string nm, input logic [3:0] ea, input logic [3:0] en);
        chk({nm, "_an"}, 16'(an), 16'(ea));
        chk({nm, "_nib"}, 16'(nibble), 16'(en));
        chk({nm, "_model_an"}, 16'(m_an()), 16'(ea));
        chk({nm, "_model_nib"}, 16'(m_nib()), 16'(en));
    endtask

    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] nib_tab[4] = '{4'hF, 4'h3, 4'hA, 4'h1};

    initial begin
        // Reset and first slot
        cyc(3);
        lit_chk("rst", 4'hF, 4'h0);
        chk("rst_fd", 16'(frame_done), 16'd0);
        chk("rst_dp", 16'(dp), 16'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lit_chk("t1", (k < 2) ? 4'hF : 4'hE, 4'h0);
            cyc(1);
        end

        // Full scan of 1A3F
        load(16'h1A3F);
        wait_until(0, 0);
        for (int k = 0; k < 32; k++) begin
            lit_chk("t2", ((k % 8) < 2) ? 4'hF : an_tab[k / 8], nib_tab[k / 8]);
            chk("t2_fd", 16'(frame_done), 16'(k == 31));
            cyc(1);
        end

        // Leading-zero suppression
        lz_blank = 1'b1;
        load(16'h0005);
        next_frame();
        wait_until(0, 4); lit_chk("t3a0", 4'hE, 4'h5);
        wait_until(1, 4); lit_chk("t3a1", 4'hF, 4'h0);
        wait_until(3, 4); lit_chk("t3a3", 4'hF, 4'h0);
        load(16'h0000);
        next_frame();
        wait_until(0, 4); lit_chk("t3b0", 4'hE, 4'h0);
        wait_until(2, 4); lit_chk("t3b2", 4'hF, 4'h0);
        lz_blank = 1'b0;
        wait_until(3, 4); lit_chk("t3c3", 4'h7, 4'h0);

        // No tearing: two loads in one frame, last wins at the next frame
        wait_until(1, 3); load(16'h1234);
        wait_until(2, 5); load(16'h5678);
        wait_until(3, 4); lit_chk("t4old", 4'h7, 4'h0);
        next_frame();
        wait_until(0, 4); lit_chk("t4n0", 4'hE, 4'h8);
        wait_until(1, 4); lit_chk("t4n1", 4'hD, 4'h7);
        wait_until(2, 4); lit_chk("t4n2", 4'hB, 4'h6);
        wait_until(3, 4); lit_chk("t4n3", 4'h7, 4'h5);

        // Load on the boundary cycle goes straight to the display
        wait_until(3, RD - 1);
        load(16'hBEEF);
        lit_chk("t5s0", 4'hF, 4'hF);
        cyc(2);
        lit_chk("t5p2", 4'hE, 4'hF);
        wait_until(1, 4); lit_chk("t5s1", 4'hD, 4'hE);

        // Partial enable, then reset during slot 2 SHOW
        digit_en = 4'b0101;
        next_frame();
        for (int k = 0; k < 32; k++) begin
            chk("t6_en", 16'(an == 4'hF || an == 4'hE || an == 4'hB), 16'd1);
            cyc(1);
        end
        wait_until(2, 4);
        lit_chk("t6pre", 4'hB, 4'hE);
        rst_n = 1'b0;
        cyc(1);
        lit_chk("t6rst", 4'hF, 4'h0);
        chk("t6rst_fd", 16'(frame_done), 16'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        lit_chk("t6rel", 4'hE, 4'h0);
        wait_until(2, 4); lit_chk("t6s2", 4'hB, 4'h0);

        // Randomized stretch against the model
        digit_en = 4'hF;
        repeat (600) begin
            value_load = ($urandom_range(0, 5) == 0);
            value_in   = 16'($urandom) >> $urandom_range(0, 16);
            if ($urandom_range(0, 40) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 30) == 0) lz_blank = 1'($urandom);
            rst_n = ($urandom_range(0, 150) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        value_load = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
